// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the CPU memory-bus initiator.
// The bus access enums and alignment check live here so datapath and bus sides agree.
package mem_if_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } mem_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  // Size code 3 is treated as a bad access alongside misaligned half/word accesses.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = addr_lo[0];
      WORD:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byteenable/writedata generation and
// load-data extraction with sign or zero extension (little-endian lanes).
module mem_lane_align
  import mem_if_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_lane,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift_s;

  // Store side: lane enables and replicated write data.
  always_comb begin
    st_be         = 4'b0000;
    st_wdata_lane = 32'h0000_0000;
    case (st_size)
      BYTE: begin
        st_be         = 4'b0001 << st_addr_lo;
        st_wdata_lane = {4{st_wdata[7:0]}};
      end
      HALF: begin
        st_be         = 4'b0011 << st_addr_lo;
        st_wdata_lane = {2{st_wdata[15:0]}};
      end
      WORD: begin
        st_be         = 4'b1111;
        st_wdata_lane = st_wdata;
      end
      default: begin
        st_be         = 4'b0000;
        st_wdata_lane = 32'h0000_0000;
      end
    endcase
  end

  // Load side: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    ld_shift_s = ld_rdata >> {ld_addr_lo, 3'b000};
    case (ld_size)
      BYTE:    ld_data = {{24{ld_signed & ld_shift_s[7]}}, ld_shift_s[7:0]};
      HALF:    ld_data = {{16{ld_signed & ld_shift_s[15]}}, ld_shift_s[15:0]};
      WORD:    ld_data = ld_rdata;
      default: ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_bus_initiator.sv
// CPU-side Avalon-MM style initiator: one load/store request becomes one bus transaction.
// Optional stall timeout is enabled with the MEM_TIMEOUT_EN macro.
module mem_bus_initiator
  import mem_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  mem_state_t  state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        busy_q, busy_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [31:0] address_q, address_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] writedata_q, writedata_d;

  logic [3:0]  st_be_s;
  logic [31:0] st_wdata_s;
  logic [31:0] ld_data_s;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
`endif

  // Store lanes come from the live request (registered on CMD entry); loads use latched fields.
  mem_lane_align u_lane_align (
    .st_size       (req_size),
    .st_addr_lo    (req_addr[1:0]),
    .st_wdata      (req_wdata),
    .st_be         (st_be_s),
    .st_wdata_lane (st_wdata_s),
    .ld_size       (size_q),
    .ld_signed     (sgn_q),
    .ld_addr_lo    (addr_lo_q),
    .ld_rdata      (readdata),
    .ld_data       (ld_data_s)
  );

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    addr_lo_d    = addr_lo_q;
    resp_rdata_d = resp_rdata_q;
    address_d    = address_q;
    byteenable_d = byteenable_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    stall_cnt_d  = CNT_W'(0);
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d    = req_size;
          sgn_d     = req_signed;
          addr_lo_d = req_addr[1:0];
          if (access_bad(req_size, req_addr[1:0])) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d      = CMD;
            read_d       = ~req_write;
            write_d      = req_write;
            address_d    = {req_addr[31:2], 2'b00};
            byteenable_d = st_be_s;
            writedata_d  = st_wdata_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CMD: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (write_q) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
          end else begin
            state_d = RDWAIT;
          end
        end else begin
`ifdef MEM_TIMEOUT_EN
          if (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            read_d       = 1'b0;
            write_d      = 1'b0;
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
          end
`else
          state_d = CMD;
`endif
        end
      end
      RDWAIT: begin
        resp_rdata_d = ld_data_s;
        state_d      = DONE;
        resp_valid_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops bus commands asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      addr_lo_q    <= 2'b00;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      address_q    <= 32'h0000_0000;
      byteenable_q <= 4'b0000;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= 32'h0000_0000;
`ifdef MEM_TIMEOUT_EN
      stall_cnt_q  <= CNT_W'(0);
`endif
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      addr_lo_q    <= addr_lo_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      address_q    <= address_d;
      byteenable_q <= byteenable_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
`ifdef MEM_TIMEOUT_EN
      stall_cnt_q  <= stall_cnt_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign address    = address_q;
  assign byteenable = byteenable_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Scoreboard bench for mem_bus_initiator: directed table, random traffic, stall timeout and reset abort.
module tb_mem_bus_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        busy, resp_valid, resp_err, read, write;
  logic [31:0] resp_rdata, address, writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = 32'd0;

  mem_bus_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .address(address), .byteenable(byteenable), .read(read), .write(write),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          cmd_cycles;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
  } txn_t;

  txn_t exp_q[$];
  txn_t obs_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_rdata = 32'd0;
  logic obs_busy_start, obs_busy_end, obs_valid_end, obs_unstable, obs_both;

  // Reference model built byte by byte.
  function automatic txn_t model(input logic w, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int stalls,
                                 input logic [31:0] prev);
    txn_t t;
    int nb;
    logic [31:0] v;
    t.err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    t.be = 4'd0; t.wd = 32'd0; v = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(addr[1:0]) && i < int'(addr[1:0]) + nb) t.be[i] = 1'b1;
      t.wd[8*i +: 8] = wdata[8*(i % nb) +: 8];
    end
    if (!t.err) begin
      for (int i = 0; i < nb; i++) v[8*i +: 8] = rdata[8*(int'(addr[1:0]) + i) +: 8];
      if (sgn && nb < 4) for (int i = 8*nb; i < 32; i++) v[i] = v[8*nb-1];
    end
    t.addr = {addr[31:2], 2'b00};
    t.rd = !w && !t.err;
    t.wr = w && !t.err;
    t.rdata = (!t.err && !w) ? v : prev;
    t.lat = t.err ? 1 : (w ? 2 + stalls : 3 + stalls);
    t.cmd_cycles = t.err ? 0 : 1 + stalls;
    return t;
  endfunction

  // Drives one request, plays the responder and pushes what the DUT produced.
  task automatic run_txn(input logic w, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int stalls);
    txn_t o;
    int start, stall_done;
    bit first, done;
    o = '{default: '0};
    first = 1'b1; done = 1'b0; stall_done = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; readdata = rdata; start = cyc;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    obs_busy_start = busy; obs_unstable = 1'b0; obs_both = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (read || write) begin
        if (first) begin
          o.be = byteenable; o.addr = address; o.wd = writedata; o.rd = read; o.wr = write;
          first = 1'b0;
        end else if ({byteenable, address, writedata, read, write} !== {o.be, o.addr, o.wd, o.rd, o.wr}) begin
          obs_unstable = 1'b1;
        end
        if (read && write) obs_both = 1'b1;
        o.cmd_cycles++;
        if (stall_done < stalls) begin waitrequest = 1'b1; stall_done++; end
        else waitrequest = 1'b0;
      end else begin
        waitrequest = 1'b1;
      end
      if (resp_valid) begin
        o.err = resp_err; o.rdata = resp_rdata; o.lat = cyc - start; done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) o.lat = -1;
    obs_valid_end = resp_valid;
    obs_busy_end = busy;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, resp_valid, resp_err, read, write, byteenable} !== 9'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {busy, resp_valid, resp_err, read, write, byteenable});
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({address, writedata, resp_rdata} !== 96'd0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h expected 0", address, writedata, resp_rdata);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  typedef struct {
    logic w; logic [1:0] size; logic sgn; logic [31:0] addr, wdata, rdata; int stalls;
    logic [3:0] be; logic [31:0] wd, rd_exp; int lat; logic err;
  } row_t;

  task automatic test_directed();
    row_t rows[10];
    txn_t e, o;
    rows[0] = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'hDEADBEEF, 32'h0, 2, 1'b0};
    rows[1] = '{1'b0, 2'd0, 1'b1, 32'h3, 32'h0, 32'h80FFFF7F, 3, 4'b1000, 32'h0, 32'hFFFFFF80, 6, 1'b0};
    rows[2] = '{1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 32'hABCD1234, 0, 4'b1100, 32'h0, 32'h0000ABCD, 3, 1'b0};
    rows[3] = '{1'b1, 2'd1, 1'b0, 32'h1, 32'h1111, 32'h0, 0, 4'b0000, 32'h0, 32'h0000ABCD, 1, 1'b1};
    rows[4] = '{1'b1, 2'd0, 1'b0, 32'h102, 32'h12345678, 32'h0, 1, 4'b0100, 32'h78787878, 32'h0000ABCD, 3, 1'b0};
    rows[5] = '{1'b1, 2'd1, 1'b0, 32'h206, 32'hCAFEBABE, 32'h0, 0, 4'b1100, 32'hBABEBABE, 32'h0000ABCD, 2, 1'b0};
    rows[6] = '{1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 32'h5555, 0, 4'b0000, 32'h0, 32'h0000ABCD, 1, 1'b1};
    rows[7] = '{1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h5555, 0, 4'b0000, 32'h0, 32'h0000ABCD, 1, 1'b1};
    rows[8] = '{1'b0, 2'd1, 1'b1, 32'h0, 32'h0, 32'h1234F00D, 0, 4'b0011, 32'h0, 32'hFFFFF00D, 3, 1'b0};
    rows[9] = '{1'b0, 2'd0, 1'b0, 32'h1, 32'h0, 32'h0000A500, 2, 4'b0010, 32'h0, 32'h000000A5, 5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      e = '{default: '0};
      e.err = rows[i].err; e.rdata = rows[i].rd_exp; e.lat = rows[i].lat;
      e.cmd_cycles = rows[i].err ? 0 : 1 + rows[i].stalls;
      e.be = rows[i].be; e.wd = rows[i].wd; e.addr = {rows[i].addr[31:2], 2'b00};
      e.rd = !rows[i].w && !rows[i].err; e.wr = rows[i].w && !rows[i].err;
      exp_q.push_back(e);
      run_txn(rows[i].w, rows[i].size, rows[i].sgn, rows[i].addr, rows[i].wdata, rows[i].rdata, rows[i].stalls);
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.lat !== e.lat) begin n_fail++; $display("FAIL row%0d latency: got %0d expected %0d", i, o.lat, e.lat); end
      n_checks++;
      if (o.err !== e.err) begin n_fail++; $display("FAIL row%0d err: got %b expected %b", i, o.err, e.err); end
      n_checks++;
      if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL row%0d rdata: got %h expected %h", i, o.rdata, e.rdata); end
      n_checks++;
      if (o.cmd_cycles !== e.cmd_cycles) begin n_fail++; $display("FAIL row%0d cmd_cycles: got %0d expected %0d", i, o.cmd_cycles, e.cmd_cycles); end
      if (!e.err) begin
        n_checks++;
        if ({o.be, o.wd, o.addr, o.rd, o.wr} !== {e.be, e.wd, e.addr, e.rd, e.wr}) begin
          n_fail++; $display("FAIL row%0d bus: got be=%b wd=%h a=%h r=%b w=%b expected be=%b wd=%h a=%h r=%b w=%b",
                             i, o.be, o.wd, o.addr, o.rd, o.wr, e.be, e.wd, e.addr, e.rd, e.wr);
        end
      end
      n_checks++;
      if ({obs_busy_start, obs_busy_end, obs_valid_end, obs_unstable, obs_both} !== 5'b10000) begin
        n_fail++; $display("FAIL row%0d handshake: got busy0=%b busy_end=%b valid_end=%b unstable=%b both=%b expected 10000",
                           i, obs_busy_start, obs_busy_end, obs_valid_end, obs_unstable, obs_both);
      end
    end
    model_rdata = 32'h000000A5;
  endtask

  task automatic test_timeout();
    txn_t e, o;
`ifdef MEM_TIMEOUT_EN
    e = '{default: '0};
    e.err = 1'b1; e.rdata = model_rdata; e.lat = 5; e.cmd_cycles = 4;
    exp_q.push_back(e);
    run_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h55AA1234, 1000);
`else
    e = model(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h55AA1234, 20, model_rdata);
    exp_q.push_back(e);
    run_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h55AA1234, 20);
`endif
    e = exp_q.pop_front(); o = obs_q.pop_front();
    n_checks++;
    if (o.lat !== e.lat) begin n_fail++; $display("FAIL stall_latency: got %0d expected %0d", o.lat, e.lat); end
    n_checks++;
    if (o.err !== e.err) begin n_fail++; $display("FAIL stall_err: got %b expected %b", o.err, e.err); end
    n_checks++;
    if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL stall_rdata: got %h expected %h", o.rdata, e.rdata); end
    n_checks++;
    if (o.cmd_cycles !== e.cmd_cycles) begin n_fail++; $display("FAIL stall_cmd_cycles: got %0d expected %0d", o.cmd_cycles, e.cmd_cycles); end
    model_rdata = e.rdata;
  endtask

  task automatic test_back_to_back();
    txn_t e, o;
    logic w, sgn;
    logic [1:0] size;
    logic [31:0] addr, wdata, rdata;
    int stalls;
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1)); sgn = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3)); addr = $urandom; wdata = $urandom; rdata = $urandom;
      stalls = $urandom_range(0, 2);
      e = model(w, size, sgn, addr, wdata, rdata, stalls, model_rdata);
      exp_q.push_back(e);
      run_txn(w, size, sgn, addr, wdata, rdata, stalls);
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if ({o.lat, o.cmd_cycles, o.err, o.rdata} !== {e.lat, e.cmd_cycles, e.err, e.rdata}) begin
        n_fail++; $display("FAIL rand%0d resp: got lat=%0d cmd=%0d err=%b rd=%h expected lat=%0d cmd=%0d err=%b rd=%h",
                           i, o.lat, o.cmd_cycles, o.err, o.rdata, e.lat, e.cmd_cycles, e.err, e.rdata);
      end
      if (!e.err) begin
        n_checks++;
        if ({o.be, o.wd, o.addr, o.rd, o.wr, obs_unstable, obs_both} !== {e.be, e.wd, e.addr, e.rd, e.wr, 2'b00}) begin
          n_fail++; $display("FAIL rand%0d bus: got be=%b wd=%h a=%h expected be=%b wd=%h a=%h", i, o.be, o.wd, o.addr, e.be, e.wd, e.addr);
        end
      end
      model_rdata = e.rdata;
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h20; readdata = 32'h13572468; waitrequest = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (read !== 1'b1) begin n_fail++; $display("FAIL abort_read_before: got %b expected 1", read); end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({read, write, busy} !== 3'b000) begin n_fail++; $display("FAIL abort_drop: got r=%b w=%b busy=%b expected 000", read, write, busy); end
    @(negedge clk);
    reset_n = 1'b1; waitrequest = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid || read || write) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL abort_no_resp: got %0d active cycles expected 0", seen); end
    n_checks++;
    if ({busy, resp_rdata} !== 33'd0) begin n_fail++; $display("FAIL abort_idle: got busy=%b rdata=%h expected 0", busy, resp_rdata); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
